// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory boot loader: the loader state
// encoding and the byte/word geometry used by the byte packer and the top.
// No ports (package only).
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

endpackage : loader_pkg

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles a little-endian 32-bit word from four pushed bytes. The first byte
// lands in bits 7:0. Shared by header (length) and payload parsing.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-low reset
//   clear    in   restart assembly at byte 0 with an empty word
//   push     in   byte_in is accepted this cycle
//   byte_in  in   8-bit stream byte
//   word     out  assembled word including any byte pushed this cycle
//   full     out  the 4th byte of a word is being accepted this cycle
// -----------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [31:0]           word_q, word_d;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d  = '0;
            word_d = '0;
        end else if (push) begin
            // Insert at the current byte lane. Earlier lanes of the previous
            // word are overwritten before they are read again.
            word_d[{idx_q, 3'b000} +: 8] = byte_in;
            idx_d = idx_q + 1'b1;
        end
    end

    // The complete word is visible in the same cycle as the 4th byte. The
    // consumer then registers it on that edge.
    assign word = word_d;
    assign full = push && !clear && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule : byte_packer

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time program loader. It parses a 32-bit little-endian word-count header
// from a valid/ready byte stream. It then writes each assembled word to
// consecutive instruction-memory addresses starting at 0. The core stays held
// in reset until the load completes.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-low reset
//   start       in   one-cycle pulse; starts a load from IDLE, DONE or ERR
//   byte_valid  in   source presents byte_data
//   byte_data   in   stream byte
//   byte_ready  out  loader accepts a byte (registered, state-derived only)
//   mem_we      out  instruction-memory write strobe, one cycle per word
//   mem_addr    out  word-aligned byte address of the write
//   mem_wdata   out  word to write
//   cpu_hold    out  high keeps the core in reset
//   done        out  load completed; sticky until next start
//   err         out  header rejected (oversize); sticky until next start
// -----------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     err
);

    localparam logic [31:0] MAX_WORDS = 32'(1) << (ADDRESS_WIDTH - 2);
    // words_left must hold MAX_WORDS itself, which needs one bit more than a
    // word index.
    localparam int WL_W = ADDRESS_WIDTH - 1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(BYTES_PER_WORD);

    loader_state_t            state_q, state_d;
    logic [WL_W-1:0]          words_left_q, words_left_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                     mem_we_q, mem_we_d;
    logic                     byte_ready_q, byte_ready_d;
    logic                     cpu_hold_q, cpu_hold_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic        pk_clear;
    logic        pk_push;
    logic [31:0] pk_word;
    logic        pk_full;

    assign pk_clear = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign pk_push  = byte_valid && byte_ready_q;

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (pk_clear),
        .push    (pk_push),
        .byte_in (byte_data),
        .word    (pk_word),
        .full    (pk_full)
    );

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d      = ST_LEN;
                    mem_addr_d   = '0;
                    words_left_d = '0;
                end
            end
            ST_LEN: begin
                if (pk_full) begin
                    if (pk_word == 32'd0) begin
                        state_d = ST_DONE;
                    end else if (pk_word > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d      = ST_DATA;
                        words_left_d = pk_word[WL_W-1:0];
                    end
                end
            end
            ST_DATA: begin
                if (pk_full) begin
                    state_d     = ST_WRITE;
                    mem_wdata_d = pk_word;
                end
            end
            ST_WRITE: begin
                words_left_d = words_left_q - 1'b1;
                if (words_left_q == WL_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    // Advance only while words remain. A full-capacity load
                    // then leaves mem_addr on its last valid address instead
                    // of wrapping to 0.
                    state_d    = ST_DATA;
                    mem_addr_d = mem_addr_q + ADDR_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobe and ready follow the next state, so they line up with the
        // registered state. done/err assert one cycle after entering their
        // state and drop on the same edge that leaves it.
        byte_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA);
        mem_we_d     = (state_d == ST_WRITE);
        done_d       = (state_q == ST_DONE) && (state_d == ST_DONE);
        err_d        = (state_q == ST_ERR) && (state_d == ST_ERR);
        cpu_hold_d   = !done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            words_left_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            byte_ready_q <= byte_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule : imem_loader
